// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs one 16-bit operation as two byte passes through an
// external 8-bit ALU (low byte, then high byte with the carry chained).
// Ports:
//   CLK, nRESET            clock, asynchronous active-low reset
//   Start, Op, OpA, OpB    operation request, opcode and operands
//   Abort                  synchronous cancel of a running operation
//   AluA, AluB, AluSub,    byte operands and controls to the ALU
//   AluCin
//   AluRes, AluCout,       same-cycle ALU result, bit-7 and bit-3 carries
//   AluHout
//   Busy, Done, Result     status and 16-bit result
//   FlagWr, FlagZWr,       flag write strobes and C/H values (DONE cycle only)
//   FlagC, FlagH
module alu16_sequencer (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [15:0] OpA,
    input  logic [15:0] OpB,
    input  logic        Abort,
    output logic [7:0]  AluA,
    output logic [7:0]  AluB,
    output logic        AluSub,
    output logic        AluCin,
    input  logic [7:0]  AluRes,
    input  logic        AluCout,
    input  logic        AluHout,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Result,
    output logic        FlagWr,
    output logic        FlagZWr,
    output logic        FlagC,
    output logic        FlagH
);

    localparam int unsigned WW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD16  = 2'b00,
        OP_INC16  = 2'b01,
        OP_DEC16  = 2'b10,
        OP_ADDSPE = 2'b11
    } op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [WW-1:0]   opa_q, opa_d;
    logic [WW-1:0]   opb_q, opb_d;
    logic [WW-1:0]   res_q, res_d;
    logic            c_lo_q, c_lo_d, h_lo_q, h_lo_d;
    logic            c_hi_q, c_hi_d, h_hi_q, h_hi_d;

    logic [BW-1:0]   alu_a_q, alu_a_d;
    logic [BW-1:0]   alu_b_q, alu_b_d;
    logic            alu_sub_q, alu_sub_d;
    logic            alu_cin_q, alu_cin_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            flag_wr_q, flag_wr_d;
    logic            flag_zwr_q, flag_zwr_d;
    logic            flag_c_q, flag_c_d;
    logic            flag_h_q, flag_h_d;

    logic            accept;
    logic [BW-1:0]   e_d;

    // Next state, operand latching and result capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        c_lo_d  = c_lo_q;
        h_lo_d  = h_lo_q;
        c_hi_d  = c_hi_q;
        h_hi_d  = h_hi_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: accept = Start;
            S_LOW: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    res_d[BW-1:0] = AluRes;
                    c_lo_d        = AluCout;
                    h_lo_d        = AluHout;
                    state_d       = S_HIGH;
                end
            end
            S_HIGH: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    res_d[WW-1:BW] = AluRes;
                    c_hi_d         = AluCout;
                    h_hi_d         = AluHout;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                accept  = Start;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_LOW;
            op_d    = op_e'(Op);
            opa_d   = OpA;
            opb_d   = OpB;
        end
    end

    // Registered outputs are computed for the state being entered
    always_comb begin
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_sub_d  = 1'b0;
        alu_cin_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        flag_wr_d  = 1'b0;
        flag_zwr_d = 1'b0;
        flag_c_d   = 1'b0;
        flag_h_d   = 1'b0;
        e_d        = opb_d[BW-1:0];

        case (state_d)
            S_LOW: begin
                busy_d  = 1'b1;
                alu_a_d = opa_d[BW-1:0];
                case (op_d)
                    OP_ADD16:  alu_b_d = opb_d[BW-1:0];
                    OP_INC16:  alu_b_d = BW'(1);
                    OP_DEC16: begin
                        // A + ~1 + 1 = A - 1; carry out means no borrow
                        alu_b_d   = BW'(1);
                        alu_sub_d = 1'b1;
                        alu_cin_d = 1'b1;
                    end
                    OP_ADDSPE: alu_b_d = e_d;
                    default:   alu_b_d = '0;
                endcase
            end
            S_HIGH: begin
                busy_d    = 1'b1;
                alu_a_d   = opa_d[WW-1:BW];
                alu_cin_d = c_lo_d;
                case (op_d)
                    OP_ADD16:  alu_b_d = opb_d[WW-1:BW];
                    OP_INC16:  alu_b_d = '0;
                    OP_DEC16: begin
                        alu_b_d   = '0;
                        alu_sub_d = 1'b1;
                    end
                    OP_ADDSPE: alu_b_d = {BW{e_d[BW-1]}};
                    default:   alu_b_d = '0;
                endcase
            end
            S_DONE: begin
                done_d = 1'b1;
                case (op_d)
                    OP_ADD16: begin
                        flag_wr_d = 1'b1;
                        flag_c_d  = c_hi_d;
                        flag_h_d  = h_hi_d;
                    end
                    OP_ADDSPE: begin
                        // SP+e flags come from the low byte only
                        flag_wr_d  = 1'b1;
                        flag_zwr_d = 1'b1;
                        flag_c_d   = c_lo_d;
                        flag_h_d   = h_lo_d;
                    end
                    default: flag_wr_d = 1'b0;
                endcase
            end
            default: busy_d = 1'b0;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD16;
            opa_q      <= '0;
            opb_q      <= '0;
            res_q      <= '0;
            c_lo_q     <= 1'b0;
            h_lo_q     <= 1'b0;
            c_hi_q     <= 1'b0;
            h_hi_q     <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sub_q  <= 1'b0;
            alu_cin_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flag_wr_q  <= 1'b0;
            flag_zwr_q <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_h_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            res_q      <= res_d;
            c_lo_q     <= c_lo_d;
            h_lo_q     <= h_lo_d;
            c_hi_q     <= c_hi_d;
            h_hi_q     <= h_hi_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sub_q  <= alu_sub_d;
            alu_cin_q  <= alu_cin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flag_wr_q  <= flag_wr_d;
            flag_zwr_q <= flag_zwr_d;
            flag_c_q   <= flag_c_d;
            flag_h_q   <= flag_h_d;
        end
    end

    assign AluA    = alu_a_q;
    assign AluB    = alu_b_q;
    assign AluSub  = alu_sub_q;
    assign AluCin  = alu_cin_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Result  = res_q;
    assign FlagWr  = flag_wr_q;
    assign FlagZWr = flag_zwr_q;
    assign FlagC   = flag_c_q;
    assign FlagH   = flag_h_q;

endmodule

// File: doc/alu16_sequencer.md
ALU16_SEQUENCER -- requirements
Module: alu16_sequencer

Interface
REQ-001 SHALL have ports: CLK in 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have ports: nRESET in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: Start in 1, operation request, sampled only when accepted (REQ-012).
REQ-004 SHALL have ports: Op in 2, operation select (00 ADD16, 01 INC16, 10 DEC16, 11 ADD_SP_E).
REQ-005 SHALL have ports: OpA in 16, first operand (HL/rr/SP); OpB in 16, second operand (ADD_SP_E uses OpB[7:0] as signed e).
REQ-006 SHALL have ports: Abort in 1, synchronous cancel.
REQ-007 SHALL have ports: AluA out 8, AluB out 8, AluSub out 1 (ALU computes AluA + (AluB ^ {8{AluSub}}) + AluCin), AluCin out 1.
REQ-008 SHALL have ports: AluRes in 8, AluCout in 1 (bit-7 carry), AluHout in 1 (bit-3 carry), combinational from ALU in the same cycle.
REQ-009 SHALL have ports: Busy out 1, Done out 1, Result out 16.
REQ-010 SHALL have ports: FlagWr out 1 (write C,H, N=0), FlagZWr out 1 (write Z=0), FlagC out 1, FlagH out 1.

Function
REQ-011 SHALL implement FSM states IDLE, LOW, HIGH, DONE; Busy=1 in LOW and HIGH only.
REQ-012 SHALL accept Start in IDLE or DONE: latch Op, OpA, OpB; next state LOW; Start in LOW/HIGH ignored.
REQ-013 SHALL in LOW drive low bytes: ADD16 A=OpA[7:0],B=OpB[7:0],Sub=0,Cin=0; INC16 B=01,Sub=0,Cin=0; DEC16 B=01,Sub=1,Cin=1; ADD_SP_E B=e,Sub=0,Cin=0.
REQ-014 SHALL at end of LOW register AluRes into Result[7:0], AluCout into internal carry c_lo, AluHout into h_lo; next state HIGH.
REQ-015 SHALL in HIGH drive A=OpA[15:8], Cin=c_lo and B: ADD16 OpB[15:8],Sub=0; INC16 00,Sub=0; DEC16 00,Sub=1; ADD_SP_E {8{e[7]}},Sub=0.
REQ-016 SHALL at end of HIGH register AluRes into Result[15:8], AluCout into c_hi, AluHout into h_hi; next state DONE.
REQ-017 SHALL in DONE assert Done=1 for exactly one cycle with Result valid; next state IDLE, or LOW if Start accepted.
REQ-018 SHALL hold Result stable from DONE until the next LOW cycle completes.
REQ-019 SHALL in DONE for ADD16 assert FlagWr=1, FlagC=c_hi, FlagH=h_hi, FlagZWr=0.
REQ-020 SHALL in DONE for ADD_SP_E assert FlagWr=1, FlagZWr=1, FlagC=c_lo, FlagH=h_lo.
REQ-021 SHALL keep FlagWr=0, FlagZWr=0 for INC16/DEC16 and in all non-DONE states.
REQ-022 SHALL drive AluA, AluB, AluSub, AluCin to 0 in IDLE and DONE.
REQ-023 SHALL latency: Start accepted at edge N -> Done high in cycle N+3.
REQ-024 SHALL on Abort=1 in LOW or HIGH go to IDLE next edge with no Done/FlagWr; Abort in IDLE/DONE has no effect; Abort wins over Start same cycle.
REQ-025 SHALL wrap modulo 2^16 (FFFF+1=0000, 0000-1=FFFF) with no overflow indication.

Reset
REQ-026 SHALL on nRESET=0 immediately force state IDLE, Busy=0, Done=0, FlagWr=0, FlagZWr=0, FlagC=0, FlagH=0, Result=0000, c_lo/c_hi/h_lo/h_hi=0, ALU drive outputs 0.
REQ-027 SHALL after nRESET deasserts accept Start on the first rising edge; reset mid-operation discards the operation without Done.

Verification
REQ-028 SHALL cover: ADD16 OpA=0FFF, OpB=0001 -> Result=1000, Done at N+3, FlagWr=1, FlagH=1, FlagC=0, FlagZWr=0.
REQ-029 SHALL cover: ADD_SP_E OpA=FFF8, e=08 -> Result=0000, FlagWr=1, FlagZWr=1, FlagC=1, FlagH=1; e=FF with OpA=1000 -> Result=0FFF, FlagC=0, FlagH=0.
REQ-030 SHALL cover: DEC16 OpA=0000 -> Result=FFFF, FlagWr=0; INC16 OpA=FFFF -> Result=0000, FlagWr=0.
REQ-031 SHALL cover: Start held during DONE -> second op enters LOW next cycle, Done pulses at N+3 and N+6; Start during LOW/HIGH ignored.
REQ-032 SHALL cover: Abort in HIGH -> IDLE, no Done, Result low byte updated only; nRESET low in HIGH -> all outputs per REQ-026 asynchronously.
